// File: rtl/debug_data_sender_pkg.sv
// Shared definitions for the debug dump path: FSM encoding, word-index map
// of the dump sequence and helpers that size the sequence from the
// register-file / data-memory depths.
package debug_data_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_WAITTX = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Word index counter width; covers the default 66-word dump.
  localparam int WIDX_W = 7;

  localparam int NREG_DEF = 32;
  localparam int NDM_DEF  = 32;

  localparam logic [WIDX_W-1:0] PC_IDX  = 7'd0;
  localparam logic [WIDX_W-1:0] CYC_IDX = 7'd1;
  localparam logic [WIDX_W-1:0] RF_BASE = 7'd2;

  // First data-memory word index for a register file of nreg entries.
  function automatic logic [WIDX_W-1:0] dm_base_idx(input int nreg);
    return RF_BASE + WIDX_W'(nreg);
  endfunction

  // Number of words in a full dump.
  function automatic logic [WIDX_W-1:0] total_words(input int nreg, input int ndm);
    return dm_base_idx(nreg) + WIDX_W'(ndm);
  endfunction

  localparam logic [WIDX_W-1:0] DM_BASE     = dm_base_idx(NREG_DEF);
  localparam logic [WIDX_W-1:0] TOTAL_WORDS = total_words(NREG_DEF, NDM_DEF);

endpackage

// File: rtl/debug_data_sender_word_serializer.sv
// Holds one debug word and presents a selected byte, most significant byte
// first (byte_sel 0 -> top byte). While load is high the byte is taken from
// the incoming word so the caller can register it in the same cycle.
module debug_data_sender_word_serializer #(
  parameter int NBITS      = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NBITS-1:0]      word_in,
  input  logic [SEL_W-1:0]      byte_sel,
  output logic [BYTE_WIDTH-1:0] byte_out
);

  localparam int NBYTES = NBITS / BYTE_WIDTH;

  logic [NBITS-1:0] word_q;
  logic [NBITS-1:0] word_d;
  logic [NBITS-1:0] src_s;
  logic [NBITS-1:0] shifted_s;

  // Capture a new word on load, otherwise hold.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = word_in;
    end else begin
      word_d = word_q;
    end
  end

  // Word buffer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= {NBITS{1'b0}};
    end else begin
      word_q <= word_d;
    end
  end

  // Byte select, MSB first.
  always_comb begin
    src_s     = load ? word_in : word_q;
    shifted_s = src_s >> (BYTE_WIDTH * (NBYTES - 1 - int'(byte_sel)));
    byte_out  = shifted_s[BYTE_WIDTH-1:0];
  end

endmodule

// File: rtl/debug_data_sender.sv
// Debug dump sender: on a rising edge of send_flag, streams PC, cycle count,
// the register file and the data memory to the UART TX, one byte per
// tx_start/tx_done handshake, and pulses send_done after the last byte.
module debug_data_sender
  import debug_data_sender_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int RF_ADDR_LENGTH = 5,
  parameter int DM_ADDR_LENGTH = 5,
  parameter int BYTE_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      send_flag,
  input  logic [NBITS-1:0]          pc_value,
  input  logic [NBITS-1:0]          cycle_count,
  input  logic [NBITS-1:0]          rf_rdata,
  input  logic [NBITS-1:0]          dm_rdata,
  input  logic                      tx_done,
  output logic [RF_ADDR_LENGTH-1:0] rf_addr,
  output logic [DM_ADDR_LENGTH-1:0] dm_addr,
  output logic                      tx_start,
  output logic [BYTE_WIDTH-1:0]     tx_data,
  output logic                      send_done,
  output logic                      busy
);

  localparam int NREG = 2 ** RF_ADDR_LENGTH;
  localparam int NDM  = 2 ** DM_ADDR_LENGTH;
  localparam logic [WIDX_W-1:0] DM_BASE_L = dm_base_idx(NREG);
  localparam logic [WIDX_W-1:0] LAST_IDX  = total_words(NREG, NDM) - 7'd1;

  state_e                    state_q, state_d;
  logic [WIDX_W-1:0]         word_idx_q, word_idx_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic                      flag_q, flag_d;
  logic                      flag_prev_q, flag_prev_d;
  logic [RF_ADDR_LENGTH-1:0] rf_addr_q, rf_addr_d;
  logic [DM_ADDR_LENGTH-1:0] dm_addr_q, dm_addr_d;
  logic                      tx_start_q, tx_start_d;
  logic [BYTE_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                      send_done_q, send_done_d;
  logic                      busy_q, busy_d;

  logic                      start_s;
  logic                      load_s;
  logic [NBITS-1:0]          word_sel_s;
  logic [BYTE_WIDTH-1:0]     ser_byte_s;

  // Flag sampled into a register first, so the edge is seen one cycle after
  // it is sampled; this sets the fixed start latency.
  always_comb begin
    flag_d      = send_flag;
    flag_prev_d = flag_q;
    start_s     = flag_q & ~flag_prev_q;
  end

  // Next-state, counters and buffer load for the dump sequence.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        word_idx_d = {WIDX_W{1'b0}};
        byte_cnt_d = 2'd0;
        if (start_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        load_s  = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAITTX;
      end
      ST_WAITTX: begin
        if (!tx_done) begin
          state_d = ST_WAITTX;
        end else if (byte_cnt_q != 2'd3) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          state_d    = ST_SEND;
        end else if (word_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + 7'd1;
          byte_cnt_d = 2'd0;
          state_d    = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Source select for the word captured at the end of LATCH.
  always_comb begin
    if (word_idx_q == PC_IDX) begin
      word_sel_s = pc_value;
    end else if (word_idx_q == CYC_IDX) begin
      word_sel_s = cycle_count;
    end else if (word_idx_q < DM_BASE_L) begin
      word_sel_s = rf_rdata;
    end else begin
      word_sel_s = dm_rdata;
    end
  end

  // Read addresses are set on entry to FETCH and held through the word, so
  // they are stable for the whole FETCH cycle before the read is captured.
  always_comb begin
    rf_addr_d = rf_addr_q;
    dm_addr_d = dm_addr_q;
    if (state_d == ST_FETCH) begin
      if ((word_idx_d >= RF_BASE) && (word_idx_d < DM_BASE_L)) begin
        rf_addr_d = RF_ADDR_LENGTH'(word_idx_d - RF_BASE);
      end else begin
        rf_addr_d = {RF_ADDR_LENGTH{1'b0}};
      end
      if ((word_idx_d >= DM_BASE_L) && (word_idx_d <= LAST_IDX)) begin
        dm_addr_d = DM_ADDR_LENGTH'(word_idx_d - DM_BASE_L);
      end else begin
        dm_addr_d = {DM_ADDR_LENGTH{1'b0}};
      end
    end else if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      rf_addr_d = {RF_ADDR_LENGTH{1'b0}};
      dm_addr_d = {DM_ADDR_LENGTH{1'b0}};
    end else begin
      rf_addr_d = rf_addr_q;
      dm_addr_d = dm_addr_q;
    end
  end

  // Registered handshake/status outputs derived from the next state.
  always_comb begin
    tx_start_d  = (state_d == ST_SEND);
    tx_data_d   = (state_d == ST_SEND) ? ser_byte_s : {BYTE_WIDTH{1'b0}};
    send_done_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  debug_data_sender_word_serializer #(
    .NBITS     (NBITS),
    .BYTE_WIDTH(BYTE_WIDTH),
    .SEL_W     (2)
  ) u_word_serializer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .word_in (word_sel_s),
    .byte_sel(byte_cnt_d),
    .byte_out(ser_byte_s)
  );

  // State, counters, flag history and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= {WIDX_W{1'b0}};
      byte_cnt_q  <= 2'd0;
      flag_q      <= 1'b0;
      flag_prev_q <= 1'b0;
      rf_addr_q   <= {RF_ADDR_LENGTH{1'b0}};
      dm_addr_q   <= {DM_ADDR_LENGTH{1'b0}};
      tx_start_q  <= 1'b0;
      tx_data_q   <= {BYTE_WIDTH{1'b0}};
      send_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      flag_q      <= flag_d;
      flag_prev_q <= flag_prev_d;
      rf_addr_q   <= rf_addr_d;
      dm_addr_q   <= dm_addr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      send_done_q <= send_done_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign dm_addr   = dm_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign send_done = send_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_debug_data_sender.sv
// Bench for debug_data_sender: a byte-stream model built from the dump
// definition (word list, MSB-first bytes) is checked against every tx_start,
// together with send_done timing, address phases and reset behaviour.
module tb_debug_data_sender;

  localparam int NWORDS     = 2 + 32 + 32;
  localparam int NBYTES_TOT = NWORDS * 4;
  localparam int RF_END_B   = (2 + 32) * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_flag;
  logic [31:0] pc_value;
  logic [31:0] cycle_count;
  logic [31:0] rf_rdata;
  logic [31:0] dm_rdata;
  logic        tx_done;
  logic [4:0]  rf_addr;
  logic [4:0]  dm_addr;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        send_done;
  logic        busy;

  logic        uart_done_s = 1'b0;
  logic        stray_s;
  int          uart_mode = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];
  logic [31:0] dm_mem [32];

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         start_cyc[$];
  int         bytes_started = 0;
  int         bytes_done = 0;
  int         done_cnt = 0;
  bit         outstanding = 1'b0;
  bit         done_pend = 1'b0;
  int         cyc_n = 0;
  int         flag_cyc = 0;

  always #5 clk = ~clk;

  assign tx_done = uart_done_s | stray_s;

  debug_data_sender dut (
    .clk        (clk),
    .reset      (reset),
    .send_flag  (send_flag),
    .pc_value   (pc_value),
    .cycle_count(cycle_count),
    .rf_rdata   (rf_rdata),
    .dm_rdata   (dm_rdata),
    .tx_done    (tx_done),
    .rf_addr    (rf_addr),
    .dm_addr    (dm_addr),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .send_done  (send_done),
    .busy       (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc_n++;

  // register file / data memory with one-cycle read latency
  always @(posedge clk) begin : mem_model
    logic [4:0] ra;
    logic [4:0] da;
    ra = rf_addr;
    da = dm_addr;
    #1;
    rf_rdata = rf_mem[ra];
    dm_rdata = dm_mem[da];
  end

  // UART TX model: mode 0 -> tx_done 10 cycles after tx_start;
  // mode 1 -> tx_done in the tx_start cycle and again 5 cycles later.
  always @(posedge clk) begin : uart_model
    int cd;
    #1;
    uart_done_s = 1'b0;
    if (reset) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) uart_done_s = 1'b1;
      end
      if (tx_start) begin
        if (uart_mode == 0) begin
          cd = 10;
        end else begin
          uart_done_s = 1'b1;
          cd = 5;
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input int idx);
    if (idx == 0) return pc_value;
    if (idx == 1) return cycle_count;
    if (idx < 34) return rf_mem[idx-2];
    return dm_mem[idx-34];
  endfunction

  // compare process: model of the byte stream and handshake rules
  always @(negedge clk) begin : cmp_proc
    bit exp_done;
    if (reset) begin
      check("reset_outputs", {13'd0, tx_start, tx_data, send_done, busy, rf_addr, dm_addr}, 32'd0);
      exp_q.delete();
      outstanding = 1'b0;
      done_pend   = 1'b0;
    end else begin
      exp_done  = done_pend;
      done_pend = 1'b0;
      check("send_done_timing", {31'd0, send_done}, {31'd0, exp_done});
      if (send_done) done_cnt++;
      if (busy) begin
        if (bytes_done < RF_END_B) check("dm_addr_zero_in_rf_phase", {27'd0, dm_addr}, 32'd0);
        else check("rf_addr_zero_in_dm_phase", {27'd0, rf_addr}, 32'd0);
      end
      if (tx_start) begin
        check("no_overlap", {31'd0, outstanding}, 32'd0);
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check($sformatf("byte_%0d", bytes_started), {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        outstanding = 1'b1;
        bytes_started++;
        rx_log.push_back(tx_data);
        start_cyc.push_back(cyc_n);
      end else if (tx_done && outstanding) begin
        outstanding = 1'b0;
        bytes_done++;
        if (bytes_done == NBYTES_TOT) done_pend = 1'b1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_dump();
    logic [31:0] w;
    exp_q.delete();
    rx_log.delete();
    start_cyc.delete();
    bytes_started = 0;
    bytes_done    = 0;
    for (int i = 0; i < NWORDS; i++) begin
      w = exp_word(i);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    send_flag = 1'b1;
    flag_cyc  = cyc_n;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      tick();
      n++;
    end
    check(nm, done_cnt, target);
    tick(2);
  endtask

  initial begin
    reset       = 1'b1;
    send_flag   = 1'b0;
    stray_s     = 1'b0;
    pc_value    = 32'h0000_0040;
    cycle_count = 32'h0000_0123;
    for (int k = 0; k < 32; k++) begin
      rf_mem[k] = 32'(k);
      dm_mem[k] = 32'hA000_0000 + 32'(k);
    end
    tick(4);
    reset = 1'b0;
    tick(3);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // stray tx_done while idle
    stray_s = 1'b1;
    tick();
    stray_s = 1'b0;
    tick(3);
    check("stray_idle_busy", {31'd0, busy}, 32'd0);

    // full dump with defaults
    start_dump();
    wait_done(1, "dump1_done");
    check("dump1_bytes", rx_log.size(), NBYTES_TOT);
    check("dump1_queue_empty", exp_q.size(), 0);
    check("lit_b0", {24'd0, rx_log[0]}, 32'h00);
    check("lit_b3", {24'd0, rx_log[3]}, 32'h40);
    check("lit_b6", {24'd0, rx_log[6]}, 32'h01);
    check("lit_b7", {24'd0, rx_log[7]}, 32'h23);
    check("lit_reg5", {24'd0, rx_log[8+5*4+3]}, 32'h05);
    check("lit_last0", {24'd0, rx_log[260]}, 32'hA0);
    check("lit_last1", {24'd0, rx_log[261]}, 32'h00);
    check("lit_last3", {24'd0, rx_log[263]}, 32'h1F);
    check("start_latency", start_cyc[0] - flag_cyc, 4);
    check("byte_gap", start_cyc[1] - start_cyc[0], 11);
    check("word_gap", start_cyc[4] - start_cyc[3], 13);

    // flag held high: no restart
    tick(500);
    check("held_no_restart_bytes", bytes_started, NBYTES_TOT);
    check("held_done_cnt", done_cnt, 1);
    check("held_busy", {31'd0, busy}, 32'd0);

    // low-then-high: second identical dump; flag drops mid-dump
    send_flag = 1'b0;
    tick(3);
    start_dump();
    tick(100);
    send_flag = 1'b0;
    wait_done(2, "dump2_done");
    check("dump2_bytes", rx_log.size(), NBYTES_TOT);
    check("dump2_queue_empty", exp_q.size(), 0);

    // early tx_done in the SEND cycle
    uart_mode = 1;
    start_dump();
    wait_done(3, "dump3_done");
    check("early_bytes", bytes_done, NBYTES_TOT);
    check("early_byte_gap", start_cyc[1] - start_cyc[0], 6);
    uart_mode = 0;
    send_flag = 1'b0;
    tick(3);

    // reset during byte 37
    pc_value = 32'h1234_5678;
    start_dump();
    for (int i = 0; i < 10000 && bytes_started < 38; i++) tick();
    check("reached_byte37", bytes_started, 38);
    reset     = 1'b1;
    send_flag = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    check("reset_no_done", done_cnt, 3);
    check("reset_busy", {31'd0, busy}, 32'd0);
    start_dump();
    wait_done(4, "dump4_done");
    check("restart_pc_msb", {24'd0, rx_log[0]}, 32'h12);
    check("dump4_bytes", rx_log.size(), NBYTES_TOT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
